// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: 8 lines x 16 bytes, zero-latency hits,
// block fill from slow memory over a read/busywait handshake, saturating hit/miss counters.
module icache_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [9:0]         pc,
  input  logic               read,
  output logic [31:0]        instruction,
  output logic               busywait,
  output logic               mem_read,
  output logic [5:0]         mem_addr,
  input  logic [127:0]       mem_readdata,
  input  logic               mem_busywait,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t       state, next_state;
  logic [127:0] data_mem [8];
  logic [2:0]   tag_mem  [8];
  logic [7:0]   valid;
  logic [127:0] fill;
  logic         post_fill;
  logic         hit;

  logic [2:0] pc_tag;
  logic [2:0] pc_index;
  assign pc_tag   = pc[9:7];
  assign pc_index = pc[6:4];

  assign hit = valid[pc_index] && (tag_mem[pc_index] == pc_tag);

  always_comb begin
    next_state  = state;
    instruction = '0;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    if (read && hit)
      instruction = data_mem[pc_index][{pc[3:2], 5'b0} +: 32];
    if (read && (!hit || state != IDLE))
      busywait = 1'b1;
    case (state)
      IDLE:     if (read && !hit) next_state = MEM_READ;
      MEM_READ: begin
        mem_read = 1'b1;
        if (!mem_busywait) next_state = UPDATE;
      end
      UPDATE:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // mem_read is decoded from state so that an asynchronous reset drops it at once.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      mem_addr   <= '0;
      post_fill  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state     <= next_state;
      post_fill <= (state == UPDATE);
      if (state == IDLE && read && !hit) begin
        mem_addr <= pc[9:4];
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
      // The retried request right after a fill was already counted as a miss.
      if (state == IDLE && read && hit && !post_fill && hit_count != '1)
        hit_count <= hit_count + 1'b1;
      if (state == UPDATE)
        valid[mem_addr[2:0]] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == MEM_READ && !mem_busywait)
      fill <= mem_readdata;
    if (state == UPDATE) begin
      data_mem[mem_addr[2:0]] <= fill;
      tag_mem[mem_addr[2:0]]  <= mem_addr[5:3];
    end
  end

endmodule
